// File: rtl/sprite_pkg.sv
// Types and constants shared by the sprite rendering blocks.
package sprite_pkg;
  typedef logic [3:0] pal_idx_t;
  typedef struct packed {logic [3:0] r, g, b;} rgb12_t;
  localparam pal_idx_t TRANSPARENT_IDX_DEFAULT = 4'h0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first set req bit at or
// after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] id
);
  int   pos;
  logic found;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        id       = W'(pos);
      end
    end
  end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin shared palette lookup: one grant per clk, 2-stage pipeline
// (S1 = accepted id/index, S2 = registered RGB response) with backpressure.
module palette_lookup_arbiter
  import sprite_pkg::*;
#(
  parameter int       NUM_REQ         = 4,
  parameter int       ID_W            = $clog2(NUM_REQ),
  parameter pal_idx_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_index,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_red,
  output logic [3:0]           rsp_green,
  output logic [3:0]           rsp_blue,
  output logic                 rsp_transparent
);
  localparam logic [11:0] PALETTE_ROM [16] = '{
    12'hFFF, 12'h443, 12'hBBB, 12'hC53, 12'h222, 12'hEDC, 12'hB76, 12'h665,
    12'h111, 12'hDA9, 12'h921, 12'h998, 12'h421, 12'hE72, 12'hA62, 12'hFEE
  };

  pal_idx_t            req_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_id;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic                stall, accept;

  logic                s1_valid_reg;
  logic [ID_W-1:0]     s1_id_reg;
  pal_idx_t            s1_idx_reg;

  logic                rsp_valid_reg, rsp_transparent_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  rgb12_t              rsp_rgb_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
      assign req_idx[gi] = req_index[4*gi +: 4];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  // No grant while the output register is blocked or the block is in reset.
  assign stall  = rsp_valid_reg && !rsp_ready;
  assign gnt    = arb_gnt & {NUM_REQ{!(stall || reset)}};
  assign accept = |(req & gnt);

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) ptr_next = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg             <= '0;
      s1_valid_reg        <= 1'b0;
      s1_id_reg           <= '0;
      s1_idx_reg          <= '0;
      rsp_valid_reg       <= 1'b0;
      rsp_id_reg          <= '0;
      rsp_rgb_reg         <= '0;
      rsp_transparent_reg <= 1'b0;
    end else if (!stall) begin
      ptr_reg      <= ptr_next;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_id_reg  <= arb_id;
        s1_idx_reg <= req_idx[arb_id];
      end
      // Bubbles only clear valid; the data registers keep their stale contents.
      rsp_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        rsp_id_reg          <= s1_id_reg;
        rsp_rgb_reg         <= rgb12_t'(PALETTE_ROM[s1_idx_reg]);
        rsp_transparent_reg <= (s1_idx_reg == TRANSPARENT_IDX);
      end
    end
  end

  assign rsp_valid       = rsp_valid_reg;
  assign rsp_id          = rsp_id_reg;
  assign rsp_red         = rsp_rgb_reg.r;
  assign rsp_green       = rsp_rgb_reg.g;
  assign rsp_blue        = rsp_rgb_reg.b;
  assign rsp_transparent = rsp_transparent_reg;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: grant order, latency, transparency,
// backpressure, wrap/skip and mid-flight reset.
module tb_palette_lookup_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_index;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_red, rsp_green, rsp_blue;
  logic        rsp_transparent;

  logic [3:0]  idx_v [4];
  logic [14:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  assign req_index = {idx_v[3], idx_v[2], idx_v[1], idx_v[0]};

  always #5 clk = ~clk;

  palette_lookup_arbiter #(.NUM_REQ(4), .ID_W(2), .TRANSPARENT_IDX(4'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_index       (req_index),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_red         (rsp_red),
    .rsp_green       (rsp_green),
    .rsp_blue        (rsp_blue),
    .rsp_transparent (rsp_transparent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input logic [1:0] id, input logic [11:0] rgb, input logic tr);
    return {tr, id, rgb};
  endfunction

  function automatic logic [14:0] rsp_word();
    return {rsp_transparent, rsp_id, rsp_red, rsp_green, rsp_blue};
  endfunction

  // Score the response presented in this cycle if it is being consumed, then advance.
  task automatic tick();
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      $display("rsp id=%0d rgb=%03h transparent=%0b", rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
      if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
      else check("rsp", 32'(rsp_word()), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  eg;
    logic [14:0] snap;
    logic [11:0] rr_rgb [4];
    int          a;

    rr_rgb = '{12'h921, 12'hE72, 12'hDA9, 12'hFEE};
    snap = '0;
    for (int i = 0; i < 4; i++) idx_v[i] = 4'h0;

    // 1: reset and single lookup
    reset = 1'b1; req = 4'h0; rsp_ready = 1'b1;
    tick();
    req = 4'hF; #1;
    check("gnt_in_reset", 32'(gnt), 32'h0);
    tick();
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h0);
    check("rst_transparent", 32'(rsp_transparent), 32'h0);
    reset = 1'b0; req = 4'b0001; idx_v[0] = 4'd3; #1;
    check("t1_gnt", 32'(gnt), 32'h1);
    exp_q.push_back(mk(2'd0, 12'hC53, 1'b0));
    tick();
    req = 4'h0;
    check("t1_valid_t1", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_valid_t2", 32'(rsp_valid), 32'h1);
    check("t1_word", 32'(rsp_word()), 32'(mk(2'd0, 12'hC53, 1'b0)));

    // 2: transparency
    req = 4'b0010; idx_v[1] = 4'd0; #1;
    check("t2_gnt", 32'(gnt), 32'h2);
    exp_q.push_back(mk(2'd1, 12'hFFF, 1'b1));
    tick();
    req = 4'h0;
    tick();
    check("t2_valid", 32'(rsp_valid), 32'h1);
    check("t2_word", 32'(rsp_word()), 32'(mk(2'd1, 12'hFFF, 1'b1)));

    // 3: round-robin (first move the pointer to 0 by serving requester 3)
    req = 4'b1000; idx_v[3] = 4'd15; #1;
    check("t3_pre_gnt", 32'(gnt), 32'h8);
    exp_q.push_back(mk(2'd3, 12'hFEE, 1'b0));
    tick();
    req = 4'hF; idx_v[0] = 4'd10; idx_v[1] = 4'd13; idx_v[2] = 4'd9; idx_v[3] = 4'd15;
    for (int k = 0; k < 8; k++) begin
      #1;
      eg = 4'b0001 << (k % 4);
      check("t3_gnt", 32'(gnt), 32'(eg));
      exp_q.push_back(mk(2'(k % 4), rr_rgb[k % 4], 1'b0));
      if (k >= 2) check("t3_back2back", 32'(rsp_valid), 32'h1);
      tick();
    end

    // 4: backpressure while streaming 0 and 2
    req = 4'b0101; idx_v[0] = 4'd5; idx_v[2] = 4'd7; a = 0;
    for (int c = 0; c < 10; c++) begin
      rsp_ready = !(c >= 4 && c <= 6);
      #1;
      if (!rsp_ready) begin
        check("t4_stall_valid", 32'(rsp_valid), 32'h1);
        check("t4_stall_gnt", 32'(gnt), 32'h0);
        if (c == 4) snap = rsp_word();
        else check("t4_stable", 32'(rsp_word()), 32'(snap));
      end else begin
        eg = (a % 2 == 0) ? 4'b0001 : 4'b0100;
        check("t4_gnt", 32'(gnt), 32'(eg));
        if (a % 2 == 0) exp_q.push_back(mk(2'd0, 12'hEDC, 1'b0));
        else exp_q.push_back(mk(2'd2, 12'h665, 1'b0));
        a++;
      end
      tick();
    end
    rsp_ready = 1'b1; req = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // 5: wrap and skip
    req = 4'b1000; idx_v[3] = 4'd15; idx_v[2] = 4'd2; #1;
    check("t5_gnt3", 32'(gnt), 32'h8);
    exp_q.push_back(mk(2'd3, 12'hFEE, 1'b0));
    tick();
    req = 4'b0100; #1;
    check("t5_skip", 32'(gnt), 32'h4);
    exp_q.push_back(mk(2'd2, 12'hBBB, 1'b0));
    tick();
    req = 4'b1001; #1;
    check("t5_ptr3", 32'(gnt), 32'h8);
    exp_q.push_back(mk(2'd3, 12'hFEE, 1'b0));
    tick();
    req = 4'h0;
    for (int i = 0; i < 3; i++) tick();

    // 6: reset mid-flight discards the in-flight lookup
    req = 4'b0001; idx_v[0] = 4'd6; #1;
    check("t6_gnt", 32'(gnt), 32'h1);
    tick();
    reset = 1'b1; req = 4'h0;
    tick();
    check("t6_valid_after_rst", 32'(rsp_valid), 32'h0);
    reset = 1'b0; req = 4'hF; #1;
    check("t6_gnt_ptr0", 32'(gnt), 32'h1);
    exp_q.push_back(mk(2'd0, 12'hB76, 1'b0));
    tick();
    req = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    check("lost_responses", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
